alu_bcd_seq: RTL

Parametrised, clocked successor to the board-level 4-bit ALU/BCD display path. It performs one of eight arithmetic/logic operations on WIDTH-bit operands after a start handshake. The result is converted to packed BCD with a sequential double-dabble engine, and it drives the 7-segment data bus and the active-low status LEDs of the Gowin board top level.

---
 rtl/alu_bcd_pkg.sv | 26 ++
 rtl/bcd_dabble.sv | 71 +++++++
 rtl/alu_bcd_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_bcd_pkg.sv
// Shared definitions for the ALU/BCD display path: opcodes, FSM states and
// the per-digit double-dabble correction.
package alu_bcd_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Digit correction applied before each shift so the digit carries at 10.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Sequential binary-to-packed-BCD converter (one double-dabble step per clock).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : capture i_bin and start a conversion (priority over a running one)
//   i_bin       : binary value, BIN_W bits
//   o_busy      : conversion in progress
//   o_valid_c   : final step happens on the coming edge; o_bcd updates there
//   o_bcd       : last completed result, digit 0 in bits [3:0]; holds otherwise
module bcd_dabble #(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_valid_c,
  output logic [4*DIGITS-1:0]   o_bcd
);
  import alu_bcd_pkg::*;

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] w_next;
  logic [3:0]       w_d;
  logic             w_carry;

  // One step: correct every digit, then shift left pulling in the binary MSB.
  always_comb begin
    w_next  = '0;
    w_d     = '0;
    w_carry = r_bin[BIN_W-1];
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_d              = dabble_adj(r_acc[4*i +: 4]);
      w_next[4*i +: 4] = {w_d[2:0], w_carry};
      w_carry          = w_d[3];
    end
  end

  assign o_valid_c = o_busy && (r_cnt == CNT_W'(BIN_W - 1));

  // Working registers stay internal; o_bcd only ever takes a finished result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      o_busy <= 1'b0;
      o_bcd  <= '0;
    end else if (i_load) begin
      r_bin  <= i_bin;
      r_acc  <= '0;
      r_cnt  <= '0;
      o_busy <= 1'b1;
    end else if (o_busy) begin
      r_bin <= r_bin << 1;
      r_acc <= w_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_valid_c) begin
        o_busy <= 1'b0;
        o_bcd  <= w_next;
      end
    end
  end

endmodule

// File: rtl/alu_bcd_seq.sv
// Clocked 8-operation ALU with sequential BCD conversion for the 7-segment bus.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_start             : request, sampled only when not busy
//   i_a, i_b, i_op_code : operands and operation, latched on accepted start
//   i_cin               : carry/borrow in, latched on accepted start
//   i_select            : display source for o_y (combinational)
//   o_busy              : high in CALC and CONV
//   o_done              : one-cycle pulse in DONE
//   o_bcd               : last converted result (packed BCD)
//   o_leds              : [0] = ~overflow, [1] = ~carry (active-low)
//   o_y                 : display bus: bcd / A / B / opcode
module alu_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_a,
  input  logic [WIDTH-1:0]      i_b,
  input  logic [2:0]            i_op_code,
  input  logic                  i_cin,
  input  logic [1:0]            i_select,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [1:0]            o_leds,
  output logic [4*DIGITS-1:0]   o_y
);
  import alu_bcd_pkg::*;

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CONV_W = WIDTH + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_cin;
  logic             r_cout;
  logic             r_ovf;

  logic [CONV_W-1:0] w_sum;
  logic [CONV_W-1:0] w_diff;
  logic [WIDTH-1:0]  w_res;
  logic              w_cout;
  logic              w_ovf;
  logic [CONV_W-1:0] w_conv;
  logic              w_load;
  logic              w_dab_busy;
  logic              w_dab_valid;

  // ALU on the latched operands; the extra top bit of sum/diff is carry/borrow.
  always_comb begin
    w_sum  = CONV_W'(r_a) + CONV_W'(r_b) + CONV_W'(r_cin);
    w_diff = CONV_W'(r_a) - CONV_W'(r_b) - CONV_W'(r_cin);
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res  = w_diff[WIDTH-1:0];
        w_cout = w_diff[WIDTH];
        w_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_SHL: begin
        w_res  = {r_a[WIDTH-2:0], 1'b0};
        w_cout = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res  = {1'b0, r_a[WIDTH-1:1]};
        w_cout = r_a[0];
      end
      default: w_res = '0;
    endcase
    // Only the adder shows its carry as the ninth display bit.
    w_conv = (r_op == OP_ADD) ? {w_cout, w_res} : {1'b0, w_res};
  end

  // Converter is loaded on the CALC->CONV edge with the freshly computed value.
  assign w_load = (r_state == S_CALC);

  bcd_dabble #(
    .BIN_W  (CONV_W),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_bin     (w_conv),
    .o_busy    (w_dab_busy),
    .o_valid_c (w_dab_valid),
    .o_bcd     (o_bcd)
  );

  // Control FSM with operand latches and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cin   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_leds  <= 2'b11;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= i_op_code;
            r_cin   <= i_cin;
            o_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_cout  <= w_cout;
          r_ovf   <= w_ovf;
          r_state <= S_CONV;
        end
        S_CONV: begin
          if (w_dab_valid) begin
            o_leds  <= {~r_cout, ~r_ovf};
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (!w_dab_busy) begin
            // Converter lost its job (cannot happen in normal flow): recover.
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= i_op_code;
            r_cin   <= i_cin;
            o_busy  <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Display source mux, zero latency from i_select.
  always_comb begin
    o_y = '0;
    case (i_select)
      2'b00:   o_y = o_bcd;
      2'b01:   o_y = BCD_W'(r_a);
      2'b10:   o_y = BCD_W'(r_b);
      default: o_y = BCD_W'(r_op);
    endcase
  end

endmodule
